// File: rtl/random_request_arbiter.sv
// rtl/random_request_arbiter.sv - round-robin shared LFSR random-number service
//
// Purpose: one free-running 12-bit LFSR time-shared among NUM_REQ requesters.
// Each grant returns one value reduced into [0, LIMIT-1] by power-of-two
// masking with rejection, falling back to a subtraction after MAX_TRIES draws.
//
// Ports:
//   CLK    clock, all logic on posedge
//   RST    synchronous active-high reset
//   REQ    per-requester request level, held until VALID with its GNT bit
//   LIMIT  per-requester exclusive bound, slice i = LIMIT[12*i+11:12*i], 0 = 4096
//   GNT    registered one-hot grant, stable from grant through the VALID cycle
//   VALUE  registered result, held until the next VALID
//   VALID  one-cycle pulse, VALUE belongs to the requester in GNT

module random_request_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter logic [11:0] SEED      = 12'h689,
  parameter int          MAX_TRIES = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ,
  input  logic [12*NUM_REQ-1:0]  LIMIT,
  output logic [NUM_REQ-1:0]     GNT,
  output logic [11:0]            VALUE,
  output logic                   VALID
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t        state;
  logic [11:0]   lfsr;
  logic [11:0]   lfsr_next;
  logic [11:0]   lim;
  logic [11:0]   mask;
  logic [11:0]   sample;
  logic          accept;
  logic [TW-1:0] tries;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic [IW:0]   cand;
  logic [11:0]   sel_lim;
  logic [11:0]   sel_mask;

  // Galois form: feedback bit r[11] rotates into bit 0 and is xored into taps 1, 4, 7.
  assign lfsr_next = {lfsr[10:0], lfsr[11]} ^ ({12{lfsr[11]}} & 12'h092);

  // First set request at or after the round-robin pointer, with wrap.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_REQ)) begin
        cand = cand - (IW+1)'(NUM_REQ);
      end
      if (!sel_found && REQ[cand[IW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IW-1:0];
      end
    end
  end

  // Smearing L-1 rightwards yields the smallest 2^k-1 >= L-1.
  // L=0 wraps to 0xFFF (full range), L=1 gives 0 (only value 0 possible).
  always_comb begin
    sel_lim  = LIMIT[12*sel_idx +: 12];
    sel_mask = sel_lim - 12'd1;
    sel_mask = sel_mask | (sel_mask >> 1);
    sel_mask = sel_mask | (sel_mask >> 2);
    sel_mask = sel_mask | (sel_mask >> 4);
    sel_mask = sel_mask | (sel_mask >> 8);
  end

  assign sample = lfsr & mask;
  assign accept = (lim == 12'd0) || (sample < lim);

  always_ff @(posedge CLK) begin
    if (RST) begin
      lfsr  <= SEED;
      state <= IDLE;
      GNT   <= '0;
      VALUE <= '0;
      VALID <= 1'b0;
      tries <= '0;
      ptr   <= '0;
      gidx  <= '0;
      lim   <= '0;
      mask  <= '0;
    end else begin
      lfsr <= lfsr_next;
      case (state)
        IDLE: begin
          if (sel_found) begin
            GNT   <= NUM_REQ'(1) << sel_idx;
            gidx  <= sel_idx;
            lim   <= sel_lim;
            mask  <= sel_mask;
            tries <= '0;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (accept) begin
            VALUE <= sample;
            VALID <= 1'b1;
            state <= DONE;
          end else if (tries == TW'(MAX_TRIES - 1)) begin
            // mask < 2L, so a rejected sample minus L is always in range
            VALUE <= sample - lim;
            VALID <= 1'b1;
            state <= DONE;
          end else begin
            tries <= tries + 1'b1;
          end
        end
        DONE: begin
          VALID <= 1'b0;
          GNT   <= '0;
          ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_request_arbiter.sv
// tb/tb_random_request_arbiter.sv - self-checking bench for random_request_arbiter
module tb_random_request_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  REQ = 4'b0;
  logic [47:0] LIMIT = 48'h0;
  logic [3:0]  GNT0, GNT1;
  logic [11:0] VALUE0, VALUE1;
  logic        VALID0, VALID1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rr_ptr = 0;
  int seq [0:10099];

  random_request_arbiter #(.NUM_REQ(4), .SEED(12'h689), .MAX_TRIES(8)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LIMIT(LIMIT),
    .GNT(GNT0), .VALUE(VALUE0), .VALID(VALID0)
  );

  random_request_arbiter #(.NUM_REQ(4), .SEED(12'h689), .MAX_TRIES(1)) dut1 (
    .CLK(CLK), .RST(RST), .REQ(REQ), .LIMIT(LIMIT),
    .GNT(GNT1), .VALUE(VALUE1), .VALID(VALID1)
  );

  always #5 CLK = ~CLK;

  // Number of non-reset edges since reset: the LFSR currently holds seq[cyc].
  always @(posedge CLK) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic void build_seq();
    logic [11:0] r, n;
    r = 12'h689;
    for (int i = 0; i < 10100; i++) begin
      seq[i] = int'(r);
      n[0] = r[11];
      for (int k = 1; k < 12; k++)
        n[k] = r[k-1] ^ (((k == 1) || (k == 4) || (k == 7)) ? r[11] : 1'b0);
      r = n;
    end
  endfunction

  // Reference: draws consume successive LFSR values after the grant edge.
  function automatic void predict(input int g, input int lv, input int mt,
                                  output int v, output int d);
    int m, s;
    v = 0; d = 0;
    m = (lv == 0) ? 4095 : 0;
    if (lv != 0) while (m < lv - 1) m = m * 2 + 1;
    for (int t = 0; t < mt; t++) begin
      s = seq[g + 1 + t] & m;
      if (lv == 0 || s < lv) begin
        v = s; d = t + 1;
        return;
      end
      if (t == mt - 1) begin
        v = s - lv; d = mt;
      end
    end
  endfunction

  function automatic int winner(input logic [3:0] req, input int ptr);
    for (int k = 0; k < 4; k++)
      if (req[(ptr + k) % 4]) return (ptr + k) % 4;
    return -1;
  endfunction

  function automatic logic [11:0] rand_limit();
    case ($urandom_range(3, 0))
      0:       return 12'd0;
      1:       return 12'($urandom_range(16, 1));
      2:       return 12'($urandom_range(4095, 1));
      default: return 12'((1 << $urandom_range(11, 0)) + $urandom_range(1, 0));
    endcase
  endfunction

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = 4'b0; LIMIT = 48'h0;
    @(negedge CLK);
    RST = 1'b0;
    rr_ptr = 0;
  endtask

  // Stimulus/observation only: present a request, collect what the DUT does.
  task automatic run_grant(input bit use1, input logic [3:0] req, input logic [47:0] lim,
                           input logic [3:0] req_after, input logic [47:0] lim_after,
                           output logic [3:0] gnt_obs, output int lat, output logic [11:0] val,
                           output logic [3:0] gnt_after, output logic valid_after,
                           output logic [11:0] val_after, output bit stable, output int g);
    REQ = req; LIMIT = lim; g = cyc;
    @(negedge CLK);
    gnt_obs = use1 ? GNT1 : GNT0;
    REQ = req_after; LIMIT = lim_after;
    lat = -1; val = 12'h0; stable = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      if ((use1 ? GNT1 : GNT0) !== gnt_obs) stable = 1'b0;
      if ((use1 ? VALID1 : VALID0) === 1'b1) begin
        lat = i; val = use1 ? VALUE1 : VALUE0;
        break;
      end
    end
    @(negedge CLK);
    gnt_after   = use1 ? GNT1 : GNT0;
    valid_after = use1 ? VALID1 : VALID0;
    val_after   = use1 ? VALUE1 : VALUE0;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1; REQ = 4'hF; LIMIT = 48'h0;
    @(negedge CLK);
    @(negedge CLK);
    checks++; if (GNT0 !== 4'b0) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", GNT0); end
    checks++; if (VALID0 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", VALID0); end
    checks++; if (VALUE0 !== 12'h0) begin errors++; $display("FAIL rst_value: got %h expected 000", VALUE0); end
    checks++; if (GNT1 !== 4'b0 || VALID1 !== 1'b0) begin errors++; $display("FAIL rst_dut1: got gnt=%b valid=%b expected 0000/0", GNT1, VALID1); end
    REQ = 4'b0;
    RST = 1'b0;
  endtask

  task automatic test_full_range();
    logic [3:0] gn, ga; int lat, g; logic [11:0] v, va; logic vf; bit st;
    apply_reset();
    run_grant(1'b0, 4'b0001, 48'h0, 4'b0001, 48'h0, gn, lat, v, ga, vf, va, st, g);
    checks++; if (gn !== 4'b0001) begin errors++; $display("FAIL fr_gnt: got %b expected 0001", gn); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL fr_latency: got %0d expected 1", lat); end
    checks++; if (v !== 12'hD12) begin errors++; $display("FAIL fr_value: got %h expected d12", v); end
    checks++; if (!st) begin errors++; $display("FAIL fr_gnt_stable: got unstable expected stable"); end
    checks++; if (ga !== 4'b0 || vf !== 1'b0) begin errors++; $display("FAIL fr_clear: got gnt=%b valid=%b expected 0000/0", ga, vf); end
    checks++; if (va !== 12'hD12) begin errors++; $display("FAIL fr_value_hold: got %h expected d12", va); end
    REQ = 4'b0;
  endtask

  task automatic test_retry_accept();
    logic [3:0] gn, ga; int lat, g; logic [11:0] v, va; logic vf; bit st;
    apply_reset();
    run_grant(1'b0, 4'b0001, 48'hA00, 4'b0001, 48'hA00, gn, lat, v, ga, vf, va, st, g);
    checks++; if (gn !== 4'b0001) begin errors++; $display("FAIL ra_gnt: got %b expected 0001", gn); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL ra_latency: got %0d expected 3", lat); end
    checks++; if (v !== 12'h5FD) begin errors++; $display("FAIL ra_value: got %h expected 5fd", v); end
    checks++; if (!st) begin errors++; $display("FAIL ra_gnt_stable: got unstable expected stable"); end
    checks++; if (vf !== 1'b0 || ga !== 4'b0) begin errors++; $display("FAIL ra_single_valid: got valid=%b gnt=%b expected 0/0000", vf, ga); end
    REQ = 4'b0;
  endtask

  task automatic test_fallback();
    logic [3:0] gn, ga; int lat, g; logic [11:0] v, va; logic vf; bit st;
    apply_reset();
    run_grant(1'b1, 4'b0001, 48'hA00, 4'b0001, 48'hA00, gn, lat, v, ga, vf, va, st, g);
    checks++; if (gn !== 4'b0001) begin errors++; $display("FAIL fb_gnt: got %b expected 0001", gn); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL fb_latency: got %0d expected 1", lat); end
    checks++; if (v !== 12'h312) begin errors++; $display("FAIL fb_value: got %h expected 312", v); end
    checks++; if (vf !== 1'b0) begin errors++; $display("FAIL fb_single_valid: got %b expected 0", vf); end
    REQ = 4'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] gn, ga, exp_g; int lat, g, ev, ed; logic [11:0] v, va; logic vf; bit st;
    logic [3:0] order [5];
    order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      run_grant(1'b0, 4'hF, {4{12'd16}}, 4'hF, {4{12'd16}}, gn, lat, v, ga, vf, va, st, g);
      exp_g = order[i];
      predict(g, 16, 8, ev, ed);
      checks++; if (gn !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gn, exp_g); end
      checks++; if (v >= 12'd16 || int'(v) != ev) begin errors++; $display("FAIL rr_value[%0d]: got %h expected %h", i, v, ev); end
      checks++; if (lat !== ed || vf !== 1'b0) begin errors++; $display("FAIL rr_valid[%0d]: got lat=%0d after=%b expected lat=%0d after=0", i, lat, vf, ed); end
    end
    REQ = 4'b0;
  endtask

  task automatic test_reset_mid_draw();
    logic [3:0] gn, ga; int lat, g; logic [11:0] v, va; logic vf; bit st;
    apply_reset();
    REQ = 4'b0001; LIMIT = 48'hA00;
    @(negedge CLK);
    checks++; if (GNT0 !== 4'b0001) begin errors++; $display("FAIL md_grant: got %b expected 0001", GNT0); end
    @(negedge CLK);
    RST = 1'b1; REQ = 4'b0;
    @(negedge CLK);
    checks++; if (GNT0 !== 4'b0 || VALID0 !== 1'b0) begin errors++; $display("FAIL md_abort: got gnt=%b valid=%b expected 0000/0", GNT0, VALID0); end
    RST = 1'b0; rr_ptr = 0;
    run_grant(1'b0, 4'b1010, 48'h0, 4'b1010, 48'h0, gn, lat, v, ga, vf, va, st, g);
    checks++; if (gn !== 4'b0010) begin errors++; $display("FAIL md_ptr_gnt: got %b expected 0010", gn); end
    checks++; if (v !== 12'hD12 || lat !== 1) begin errors++; $display("FAIL md_lfsr: got value=%h lat=%0d expected d12/1", v, lat); end
    REQ = 4'b0;
  endtask

  task automatic test_soak();
    logic [3:0] gn, ga, pend, req_after; int lat, g, ev, ed, w, gi, ntx;
    logic [11:0] v, va; logic vf; bit st;
    logic [47:0] lim, lim_after;
    logic [11:0] lv [4];
    int waits [4];
    apply_reset();
    pend = 4'b0; ntx = 0;
    for (int i = 0; i < 4; i++) begin lv[i] = 12'd0; waits[i] = 0; end
    while (cyc < 9000 && ntx < 4000) begin
      for (int i = 0; i < 4; i++)
        if (!pend[i] && $urandom_range(1, 0) == 1) begin pend[i] = 1'b1; lv[i] = rand_limit(); end
      if (pend == 4'b0) pend[$urandom_range(3, 0)] = 1'b1;
      lim = {lv[3], lv[2], lv[1], lv[0]};
      w = winner(pend, rr_ptr);
      lim_after = {rand_limit(), rand_limit(), rand_limit(), rand_limit()};
      req_after = pend;
      if ($urandom_range(3, 0) == 0) req_after[w] = 1'b0;
      run_grant(1'b0, pend, lim, req_after, lim_after, gn, lat, v, ga, vf, va, st, g);
      predict(g, int'(lv[w]), 8, ev, ed);
      checks++; if (gn !== 4'(1 << w)) begin errors++; $display("FAIL soak_gnt[%0d]: got %b expected %b", ntx, gn, 4'(1 << w)); end
      checks++; if (lat !== ed) begin errors++; $display("FAIL soak_latency[%0d]: got %0d expected %0d", ntx, lat, ed); end
      checks++; if (int'(v) != ev) begin errors++; $display("FAIL soak_value[%0d]: got %h expected %h (L=%h)", ntx, v, ev, lv[w]); end
      checks++; if (lv[w] != 12'd0 && v >= lv[w]) begin errors++; $display("FAIL soak_range[%0d]: got %h expected below %h", ntx, v, lv[w]); end
      checks++; if (!st || ga !== 4'b0 || vf !== 1'b0) begin errors++; $display("FAIL soak_handshake[%0d]: got stable=%0d gnt_after=%b valid_after=%b expected 1/0000/0", ntx, st, ga, vf); end
      gi = -1;
      for (int i = 0; i < 4; i++) if (gn == 4'(1 << i)) gi = i;
      for (int i = 0; i < 4; i++) begin
        if (i == gi) waits[i] = 0;
        else if (pend[i]) begin
          waits[i]++;
          checks++; if (waits[i] >= 4) begin errors++; $display("FAIL soak_starve[%0d]: got wait %0d for req %0d expected below 4", ntx, waits[i], i); end
        end
      end
      pend[w] = 1'b0;
      waits[w] = 0;
      for (int i = 0; i < 4; i++) lv[i] = lim_after[12*i +: 12];
      rr_ptr = (w + 1) % 4;
      ntx++;
    end
    REQ = 4'b0;
  endtask

  initial begin
    build_seq();
    test_reset();
    test_full_range();
    test_retry_accept();
    test_fallback();
    test_round_robin();
    test_reset_mid_draw();
    test_soak();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
